multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle MIPS control unit: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and write-back. It replaces the single-cycle combinational opcode decoder. Outputs drive the datapath muxes, register file, ALU control and PC update logic. Memory phases stall on a ready handshake, and HALT or illegal opcodes park the machine until reset.

## Interface
- OPCODE_W, default 6: opcode field width.
- ALU_OP_W, default 2: ALU-control class width. Encodings: 00 add, 01 sub, 10 funct, 11 or-imm.
- CNT_W, default 32: performance counter width. Only used when the configuration macro is defined.

Ports (clock and reset first):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  leave IDLE and start fetching.
- opcode  in  OPCODE_W  instruction opcode field, valid in DECODE.
- mem_ready  in  1  memory completes this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- i_or_d  out  1  memory address source: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  destination register: 0 rt, 1 rd.
- write_data_select  out  1  register write data: 0 ALUOut, 1 MDR.
- alu_src_a  out  1  ALU operand A: 0 PC, 1 rs.
- alu_src_b  out  2  ALU operand B: 00 rt, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate.
- alu_op  out  ALU_OP_W  ALU-control class.
- halted  out  1  machine parked in HALT.
- illegal  out  1  sticky; set when an unknown opcode was decoded.
- state  out  4  current state, for debug.

## Operation
- States: IDLE, FETCH, DECODE, EX_R, EX_ADDR, EX_ADDI, EX_BEQ, EX_J, MEM_RD, MEM_WR, WB_R, WB_MEM, WB_ADDI, HALT.
- Opcodes: R-type 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010, HALT 111111.
- IDLE: all outputs 0. Go to FETCH when run=1.
- FETCH: mem_read=1, alu_src_b=01, alu_op=00. While mem_ready=0, hold FETCH with pc_write=0 and ir_write=0. When mem_ready=1, assert ir_write=1 and pc_write=1, then go to DECODE.
- DECODE: alu_src_b=11 (branch target into ALUOut). Capture opcode into an internal register. Dispatch:
  - R-type → EX_R
  - LW/SW → EX_ADDR
  - ADDI → EX_ADDI
  - BEQ → EX_BEQ
  - J → EX_J
  - HALT → HALT
  - any other opcode → HALT, with illegal set
- EX_R: alu_src_a=1, alu_op=10. Next: WB_R.
- WB_R: reg_write=1, reg_dst=1. Next: FETCH.
- EX_ADDR: alu_src_a=1, alu_src_b=10. Next: MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready=1, then go to WB_MEM.
- WB_MEM: reg_write=1, write_data_select=1. Next: FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready=1, then go to FETCH.
- EX_ADDI: alu_src_a=1, alu_src_b=10, alu_op=00. Next: WB_ADDI.
- WB_ADDI: reg_write=1, reg_dst=0, write_data_select=0. Next: FETCH.
- EX_BEQ: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01. Next: FETCH.
- EX_J: pc_write=1, pc_source=10. Next: FETCH.
- HALT: all strobes 0, halted=1. Exit only via reset; run is ignored.
- Outputs are decoded from the state register and the captured opcode only. The one exception is FETCH's ir_write/pc_write, which are gated by mem_ready.

## Timing
- Reset (asynchronous): state=IDLE, illegal=0, captured opcode=0. Every output is 0 while reset is high.
- Reset mid-instruction: aborts within the same cycle. No write strobe may be asserted after reset rises.
- Zero-wait cycle counts, FETCH through the last state inclusive: R 4, LW 5, SW 4, ADDI 4, BEQ 3, J 3.
- Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- mem_ready is ignored in every other state.
- run pulsing while not in IDLE has no effect.

## Configuration
- MCU_PERF_COUNTERS_EN defined:
  - Adds outputs cycle_count[CNT_W] and instr_retired[CNT_W].
  - cycle_count increments every cycle outside IDLE and HALT.
  - instr_retired increments on the transition into FETCH from any non-IDLE state.
  - Both counters wrap modulo 2^CNT_W and reset to 0.
- Undefined: neither counter nor its ports exist.

## Structure
- Package mcu_pkg holds:
  - the state enum
  - opcode constants
  - alu_op and pc_source encodings
- Sub-module mcu_decode: combinational mapping from the captured opcode to the dispatch state and the illegal flag. Shared with the next pipelined control generation.

## Test plan
- Reset, then run=1 for 1 cycle with opcode=000000 and mem_ready=1 → FETCH, DECODE, EX_R, WB_R, FETCH; reg_write=1 and reg_dst=1 only in WB_R.
- LW with mem_ready low for 2 cycles in MEM_RD → 7 cycles total; write_data_select=1 and reg_write=1 exactly once.
- SW → mem_write=1 with i_or_d=1 while in MEM_WR; reg_write never asserted.
- BEQ, then J → pc_write_cond=1 and pc_source=01 in EX_BEQ; pc_write=1 and pc_source=10 in EX_J; each instruction takes 3 cycles.
- Opcode 111111 → HALT, halted=1, illegal=0. Opcode 111110 → HALT, illegal=1. run is ignored in both cases; reset returns to IDLE.
- Reset asserted asynchronously in MEM_WR → mem_write falls before the next clock edge. With MCU_PERF_COUNTERS_EN: 3 retired instructions give instr_retired=3.

Source files
------------

// File: rtl/mcu_pkg.sv
// mcu_pkg: shared definitions for the multi-cycle MIPS control unit.
//   - state_t        : FSM state encoding (also visible on the debug 'state' port)
//   - OP_*           : opcode field values recognised by the decoder
//   - ALU_* / PC_SRC_* / SRCB_* : encodings driven onto the datapath selects
package mcu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_EX_R    = 4'd3,
    ST_EX_ADDR = 4'd4,
    ST_EX_ADDI = 4'd5,
    ST_EX_BEQ  = 4'd6,
    ST_EX_J    = 4'd7,
    ST_MEM_RD  = 4'd8,
    ST_MEM_WR  = 4'd9,
    ST_WB_R    = 4'd10,
    ST_WB_MEM  = 4'd11,
    ST_WB_ADDI = 4'd12,
    ST_HALT    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_ORI   = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mcu_decode.sv
// mcu_decode: purely combinational opcode dispatch for the control unit.
// Ports:
//   opcode         in  [OPCODE_W]  opcode field to classify
//   dispatch_state out [4]         state_t encoding of the first execute state
//   illegal_op     out 1           opcode is not one the machine implements
// Unknown opcodes dispatch to HALT so the machine parks instead of guessing.
module mcu_decode
  import mcu_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [3:0]          dispatch_state,
  output logic                illegal_op
);

  // Map each implemented opcode onto its execute state; everything else is illegal.
  always_comb begin
    dispatch_state = ST_HALT;
    illegal_op     = 1'b0;
    case (opcode)
      OPCODE_W'(OP_RTYPE): dispatch_state = ST_EX_R;
      OPCODE_W'(OP_LW):    dispatch_state = ST_EX_ADDR;
      OPCODE_W'(OP_SW):    dispatch_state = ST_EX_ADDR;
      OPCODE_W'(OP_ADDI):  dispatch_state = ST_EX_ADDI;
      OPCODE_W'(OP_BEQ):   dispatch_state = ST_EX_BEQ;
      OPCODE_W'(OP_J):     dispatch_state = ST_EX_J;
      OPCODE_W'(OP_HALT):  dispatch_state = ST_HALT;
      default: begin
        dispatch_state = ST_HALT;
        illegal_op     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing MIPS instructions through
// fetch / decode / execute / memory / write-back.
// Ports:
//   clk, reset (async, active-high)
//   run        : leave IDLE and start fetching
//   opcode     : instruction opcode, sampled in DECODE
//   mem_ready  : memory handshake, only looked at in FETCH, MEM_RD, MEM_WR
//   pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
//   ir_write, reg_write, reg_dst, write_data_select, alu_src_a, alu_src_b,
//   alu_op     : datapath controls
//   halted     : parked in HALT (only reset leaves it)
//   illegal    : sticky, an unknown opcode was decoded
//   state      : current state encoding for debug
// Optional build macro MCU_PERF_COUNTERS_EN adds cycle_count and
// instr_retired outputs (CNT_W bits each, wrapping).
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALU_OP_W = 2,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                write_data_select,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                halted,
  output logic                illegal,
  output logic [3:0]          state
`ifdef MCU_PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    instr_retired
`endif
);

  state_t                state_q;
  state_t                next_state;
  logic [OPCODE_W-1:0]   opcode_q;
  logic                  illegal_q;
  logic [3:0]            dispatch_state;
  logic                  illegal_op;
  logic [1:0]            alu_class;

  // The live opcode drives dispatch because DECODE must pick the execute
  // state in the same cycle the opcode is presented.
  mcu_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_decode (
    .opcode         (opcode),
    .dispatch_state (dispatch_state),
    .illegal_op     (illegal_op)
  );

  // State register plus the opcode/illegal capture taken at the end of DECODE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= next_state;
      if (state_q == ST_DECODE) begin
        opcode_q <= opcode;
        if (illegal_op) begin
          illegal_q <= 1'b1;
        end
      end
    end
  end

  // Next-state and Moore outputs; FETCH is the only place mem_ready gates
  // strobes, so the IR/PC only load when the instruction word is valid.
  always_comb begin
    next_state        = state_q;
    pc_write          = 1'b0;
    pc_write_cond     = 1'b0;
    pc_source         = PC_SRC_ALU;
    i_or_d            = 1'b0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    ir_write          = 1'b0;
    reg_write         = 1'b0;
    reg_dst           = 1'b0;
    write_data_select = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = SRCB_RT;
    alu_class         = ALU_ADD;
    halted            = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          next_state = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_class = ALU_ADD;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b  = SRCB_IMM_SH;
        next_state = state_t'(dispatch_state);
      end
      ST_EX_R: begin
        alu_src_a  = 1'b1;
        alu_class  = ALU_FUNCT;
        next_state = ST_WB_R;
      end
      ST_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        next_state = ST_FETCH;
      end
      ST_EX_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = (opcode_q == OPCODE_W'(OP_LW)) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          next_state = ST_WB_MEM;
        end
      end
      ST_WB_MEM: begin
        reg_write         = 1'b1;
        write_data_select = 1'b1;
        next_state        = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          next_state = ST_FETCH;
        end
      end
      ST_EX_ADDI: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_class  = ALU_ADD;
        next_state = ST_WB_ADDI;
      end
      ST_WB_ADDI: begin
        reg_write  = 1'b1;
        next_state = ST_FETCH;
      end
      ST_EX_BEQ: begin
        alu_src_a     = 1'b1;
        alu_class     = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PC_SRC_ALUOUT;
        next_state    = ST_FETCH;
      end
      ST_EX_J: begin
        pc_write   = 1'b1;
        pc_source  = PC_SRC_JUMP;
        next_state = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  assign alu_op  = ALU_OP_W'(alu_class);
  assign illegal = illegal_q;
  assign state   = state_q;

`ifdef MCU_PERF_COUNTERS_EN
  logic [CNT_W-1:0] cycle_count_q;
  logic [CNT_W-1:0] instr_retired_q;

  // Busy-cycle and retirement counters; a FETCH->FETCH memory stall is not
  // a retirement, only arriving in FETCH from a finished instruction is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count_q   <= '0;
      instr_retired_q <= '0;
    end else begin
      if (state_q != ST_IDLE && state_q != ST_HALT) begin
        cycle_count_q <= cycle_count_q + 1'b1;
      end
      if (next_state == ST_FETCH && state_q != ST_IDLE && state_q != ST_FETCH) begin
        instr_retired_q <= instr_retired_q + 1'b1;
      end
    end
  end

  assign cycle_count   = cycle_count_q;
  assign instr_retired = instr_retired_q;
`else
  // Counter width still has to be a sane value so both builds share one
  // parameter set.
  if (CNT_W < 1) begin : g_cnt_w_invalid
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard bench for the multi-cycle control unit.
// Each cycle's inputs and the expected {state, controls, illegal} are queued,
// then replayed one entry per clock and compared at negedge + 1.
module tb_multicycle_control_unit;
  import mcu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, write_data_select, alu_src_a, halted, illegal;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state;
`ifdef MCU_PERF_COUNTERS_EN
  logic [31:0] cycle_count, instr_retired;
`endif

  int total = 0;
  int bad   = 0;
  bit run_noise = 1'b0;

  // Control word layout:
  // [16]pc_write [15]pc_write_cond [14:13]pc_source [12]i_or_d [11]mem_read
  // [10]mem_write [9]ir_write [8]reg_write [7]reg_dst [6]write_data_select
  // [5]alu_src_a [4:3]alu_src_b [2:1]alu_op [0]halted
  localparam logic [16:0] C_NONE       = 17'h00000;
  localparam logic [16:0] C_FETCH_WAIT = 17'h00808;
  localparam logic [16:0] C_FETCH_GO   = 17'h10A08;
  localparam logic [16:0] C_DECODE     = 17'h00018;
  localparam logic [16:0] C_EX_R       = 17'h00024;
  localparam logic [16:0] C_WB_R       = 17'h00180;
  localparam logic [16:0] C_EX_ADDR    = 17'h00030;
  localparam logic [16:0] C_MEM_RD     = 17'h01800;
  localparam logic [16:0] C_WB_MEM     = 17'h00140;
  localparam logic [16:0] C_MEM_WR     = 17'h01400;
  localparam logic [16:0] C_EX_ADDI    = 17'h00030;
  localparam logic [16:0] C_WB_ADDI    = 17'h00100;
  localparam logic [16:0] C_EX_BEQ     = 17'h0A022;
  localparam logic [16:0] C_EX_J       = 17'h14000;
  localparam logic [16:0] C_HALT       = 17'h00001;

  typedef struct {
    logic        run;
    logic [5:0]  op;
    logic        rdy;
    logic [21:0] exp;
  } sb_t;

  sb_t sb[$];

  multicycle_control_unit dut (
    .clk               (clk),
    .reset             (reset),
    .run               (run),
    .opcode            (opcode),
    .mem_ready         (mem_ready),
    .pc_write          (pc_write),
    .pc_write_cond     (pc_write_cond),
    .pc_source         (pc_source),
    .i_or_d            (i_or_d),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .ir_write          (ir_write),
    .reg_write         (reg_write),
    .reg_dst           (reg_dst),
    .write_data_select (write_data_select),
    .alu_src_a         (alu_src_a),
    .alu_src_b         (alu_src_b),
    .alu_op            (alu_op),
    .halted            (halted),
    .illegal           (illegal),
    .state             (state)
`ifdef MCU_PERF_COUNTERS_EN
    ,
    .cycle_count       (cycle_count),
    .instr_retired     (instr_retired)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [21:0] observe();
    return {state, pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
            ir_write, reg_write, reg_dst, write_data_select, alu_src_a, alu_src_b,
            alu_op, halted, illegal};
  endfunction

  function automatic logic noise();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic sb_push(input logic r, input logic [5:0] op, input logic rdy,
                         input state_t st, input logic [16:0] c, input logic ill);
    sb_t e;
    e.run = r;
    e.op  = op;
    e.rdy = rdy;
    e.exp = {4'(st), c, ill};
    sb.push_back(e);
  endtask

  // After DECODE the opcode bus carries op with bit 3 flipped (LW<->SW), so
  // only the captured opcode can steer EX_ADDR correctly.
  task automatic push_instr(input logic [5:0] op, input int fetch_wait,
                            input int mem_wait, input logic ill);
    logic [5:0] junk;
    junk = op ^ 6'b001000;
    for (int i = 0; i < fetch_wait; i++) sb_push(run_noise, op, 1'b0, ST_FETCH, C_FETCH_WAIT, ill);
    sb_push(run_noise, op, 1'b1, ST_FETCH, C_FETCH_GO, ill);
    sb_push(run_noise, op, noise(), ST_DECODE, C_DECODE, ill);
    case (op)
      OP_RTYPE: begin
        sb_push(run_noise, junk, noise(), ST_EX_R, C_EX_R, ill);
        sb_push(run_noise, junk, noise(), ST_WB_R, C_WB_R, ill);
      end
      OP_LW: begin
        sb_push(run_noise, junk, noise(), ST_EX_ADDR, C_EX_ADDR, ill);
        for (int i = 0; i < mem_wait; i++) sb_push(run_noise, junk, 1'b0, ST_MEM_RD, C_MEM_RD, ill);
        sb_push(run_noise, junk, 1'b1, ST_MEM_RD, C_MEM_RD, ill);
        sb_push(run_noise, junk, noise(), ST_WB_MEM, C_WB_MEM, ill);
      end
      OP_SW: begin
        sb_push(run_noise, junk, noise(), ST_EX_ADDR, C_EX_ADDR, ill);
        for (int i = 0; i < mem_wait; i++) sb_push(run_noise, junk, 1'b0, ST_MEM_WR, C_MEM_WR, ill);
        sb_push(run_noise, junk, 1'b1, ST_MEM_WR, C_MEM_WR, ill);
      end
      OP_ADDI: begin
        sb_push(run_noise, junk, noise(), ST_EX_ADDI, C_EX_ADDI, ill);
        sb_push(run_noise, junk, noise(), ST_WB_ADDI, C_WB_ADDI, ill);
      end
      OP_BEQ: sb_push(run_noise, junk, noise(), ST_EX_BEQ, C_EX_BEQ, ill);
      OP_J:   sb_push(run_noise, junk, noise(), ST_EX_J, C_EX_J, ill);
      default: ;
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; opcode = 6'h3F; mem_ready = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (observe() !== 22'h0) begin
      bad++;
      $display("[TB] FAIL reset_hold: observed %h required %h", observe(), 22'h0);
    end
    @(negedge clk);
    reset = 1'b0; run = 1'b0;
    #1;
    total++;
    if (observe() !== 22'h0) begin
      bad++;
      $display("[TB] FAIL reset_idle: observed %h required %h", observe(), 22'h0);
    end
    @(negedge clk);
  endtask

  task automatic test_rtype();
    sb_t e;
    sb_push(1'b1, OP_RTYPE, 1'b1, ST_IDLE, C_NONE, 1'b0);
    push_instr(OP_RTYPE, 0, 0, 1'b0);
    sb_push(1'b0, OP_LW, 1'b0, ST_FETCH, C_FETCH_WAIT, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      run = e.run; opcode = e.op; mem_ready = e.rdy;
      #1;
      total++;
      if (observe() !== e.exp) begin
        bad++;
        $display("[TB] FAIL rtype: observed %h required %h", observe(), e.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lw();
    sb_t e;
    push_instr(OP_LW, 0, 2, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      run = e.run; opcode = e.op; mem_ready = e.rdy;
      #1;
      total++;
      if (observe() !== e.exp) begin
        bad++;
        $display("[TB] FAIL lw: observed %h required %h", observe(), e.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw_addi();
    sb_t e;
    push_instr(OP_SW, 0, 0, 1'b0);
    push_instr(OP_ADDI, 1, 0, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      run = e.run; opcode = e.op; mem_ready = e.rdy;
      #1;
      total++;
      if (observe() !== e.exp) begin
        bad++;
        $display("[TB] FAIL sw_addi: observed %h required %h", observe(), e.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_beq_j();
    sb_t e;
    push_instr(OP_BEQ, 0, 0, 1'b0);
    push_instr(OP_J, 0, 0, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      run = e.run; opcode = e.op; mem_ready = e.rdy;
      #1;
      total++;
      if (observe() !== e.exp) begin
        bad++;
        $display("[TB] FAIL beq_j: observed %h required %h", observe(), e.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    sb_t e;
    run_noise = 1'b1;
    push_instr(OP_RTYPE, 2, 0, 1'b0);
    push_instr(OP_LW, 0, 1, 1'b0);
    push_instr(OP_SW, 1, 2, 1'b0);
    push_instr(OP_ADDI, 0, 0, 1'b0);
    push_instr(OP_BEQ, 0, 0, 1'b0);
    push_instr(OP_J, 0, 0, 1'b0);
    run_noise = 1'b0;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      run = e.run; opcode = e.op; mem_ready = e.rdy;
      #1;
      total++;
      if (observe() !== e.exp) begin
        bad++;
        $display("[TB] FAIL back_to_back: observed %h required %h", observe(), e.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_halt();
    sb_t e;
    push_instr(OP_HALT, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) sb_push(1'b1, OP_RTYPE, 1'b1, ST_HALT, C_HALT, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      run = e.run; opcode = e.op; mem_ready = e.rdy;
      #1;
      total++;
      if (observe() !== e.exp) begin
        bad++;
        $display("[TB] FAIL halt: observed %h required %h", observe(), e.exp);
      end
      @(negedge clk);
    end
    run = 1'b0;
    reset = 1'b1;
    #2;
    total++;
    if (observe() !== 22'h0) begin
      bad++;
      $display("[TB] FAIL halt_reset: observed %h required %h", observe(), 22'h0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_illegal();
    sb_t e;
    sb_push(1'b1, 6'b111110, 1'b1, ST_IDLE, C_NONE, 1'b0);
    push_instr(6'b111110, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) sb_push(1'b1, OP_RTYPE, 1'b1, ST_HALT, C_HALT, 1'b1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      run = e.run; opcode = e.op; mem_ready = e.rdy;
      #1;
      total++;
      if (observe() !== e.exp) begin
        bad++;
        $display("[TB] FAIL illegal: observed %h required %h", observe(), e.exp);
      end
      @(negedge clk);
    end
    run = 1'b0;
    reset = 1'b1;
    #2;
    total++;
    if (illegal !== 1'b0 || state !== 4'(ST_IDLE)) begin
      bad++;
      $display("[TB] FAIL illegal_clear: observed illegal=%b state=%0d required illegal=0 state=%0d",
               illegal, state, 4'(ST_IDLE));
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_async_reset();
    sb_t e;
    sb_push(1'b1, OP_SW, 1'b1, ST_IDLE, C_NONE, 1'b0);
    sb_push(1'b0, OP_SW, 1'b1, ST_FETCH, C_FETCH_GO, 1'b0);
    sb_push(1'b0, OP_SW, 1'b0, ST_DECODE, C_DECODE, 1'b0);
    sb_push(1'b0, OP_LW, 1'b1, ST_EX_ADDR, C_EX_ADDR, 1'b0);
    sb_push(1'b0, OP_LW, 1'b0, ST_MEM_WR, C_MEM_WR, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      run = e.run; opcode = e.op; mem_ready = e.rdy;
      #1;
      total++;
      if (observe() !== e.exp) begin
        bad++;
        $display("[TB] FAIL async_reset_seq: observed %h required %h", observe(), e.exp);
      end
      @(negedge clk);
    end
    // Still stalled in MEM_WR; raise reset mid-cycle, well before the next edge.
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (mem_write !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_reset_mem_write: observed %b required 0", mem_write);
    end
    total++;
    if (observe() !== 22'h0) begin
      bad++;
      $display("[TB] FAIL async_reset_all: observed %h required %h", observe(), 22'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
  endtask

`ifdef MCU_PERF_COUNTERS_EN
  task automatic test_perf_counters();
    sb_t e;
    sb_push(1'b1, OP_RTYPE, 1'b1, ST_IDLE, C_NONE, 1'b0);
    push_instr(OP_RTYPE, 0, 0, 1'b0);
    push_instr(OP_BEQ, 0, 0, 1'b0);
    push_instr(OP_J, 0, 0, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      run = e.run; opcode = e.op; mem_ready = e.rdy;
      #1;
      total++;
      if (observe() !== e.exp) begin
        bad++;
        $display("[TB] FAIL perf_seq: observed %h required %h", observe(), e.exp);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (instr_retired !== 32'd3) begin
      bad++;
      $display("[TB] FAIL perf_retired: observed %0d required 3", instr_retired);
    end
    total++;
    if (cycle_count !== 32'd10) begin
      bad++;
      $display("[TB] FAIL perf_cycles: observed %0d required 10", cycle_count);
    end
    reset = 1'b1;
    #1;
    total++;
    if (instr_retired !== 32'd0 || cycle_count !== 32'd0) begin
      bad++;
      $display("[TB] FAIL perf_reset: observed retired=%0d cycles=%0d required 0 0",
               instr_retired, cycle_count);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask
`endif

  initial begin
    $display("[TB] starting multicycle_control_unit bench");
    test_reset();
    test_rtype();
    test_lw();
    test_sw_addi();
    test_beq_j();
    test_back_to_back();
    test_halt();
    test_illegal();
    test_async_reset();
`ifdef MCU_PERF_COUNTERS_EN
    test_perf_counters();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
